// File: rtl/full_adder.sv
// full_adder: clocked, parameterizable binary adder computing {cout, A} = x + y + cin.
//
// Parameters:
//   WIDTH        operand/sum width in bits (1..64)
//   PIPE_STAGES  register stages from inputs to outputs (0, 1 or 2)
//
// Ports:
//   clk    rising-edge clock (unused when PIPE_STAGES = 0)
//   rst_n  synchronous active-low reset, clears every pipeline register
//   x, y   operands
//   cin    carry-in
//   A      sum, (x + y + cin) mod 2^WIDTH
//   cout   carry-out, bit WIDTH of x + y + cin
module full_adder #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] A,
  output logic             cout
);

  // Carry chain split point for the two-stage pipeline: low half gets the extra bit.
  localparam int unsigned LoW = (WIDTH + 1) / 2;
  localparam int unsigned HiW = WIDTH - LoW;

  generate
    if (PIPE_STAGES == 0) begin : g_comb
      logic [WIDTH:0] sum_full;
      // Clock and reset have no function in the purely combinational build.
      logic           unused_clk_rst;

      assign unused_clk_rst = clk ^ rst_n;
      assign sum_full       = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      assign {cout, A}      = sum_full;

    end else if (PIPE_STAGES == 1) begin : g_pipe1
      logic [WIDTH:0] sum_full;
      logic [WIDTH:0] res_q;

      assign sum_full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_q <= '0;
        end else begin
          res_q <= sum_full;
        end
      end

      assign {cout, A} = res_q;

    end else if (HiW == 0) begin : g_pipe2_narrow
      // Single-bit adder: nothing to split, stage 2 only delays the stage-1 result.
      logic [WIDTH:0] sum_full;
      logic [WIDTH:0] s1_q;
      logic [WIDTH:0] res_q;

      assign sum_full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_q  <= '0;
          res_q <= '0;
        end else begin
          s1_q  <= sum_full;
          res_q <= s1_q;
        end
      end

      assign {cout, A} = res_q;

    end else begin : g_pipe2_split
      logic [LoW:0]   lo_sum;
      logic [LoW:0]   lo_q;    // lo_q[LoW] is the intermediate carry into the upper half
      logic [HiW-1:0] x_hi_q;
      logic [HiW-1:0] y_hi_q;
      logic [HiW:0]   hi_sum;
      logic [WIDTH:0] res_q;

      assign lo_sum = {1'b0, x[LoW-1:0]} + {1'b0, y[LoW-1:0]} + {{LoW{1'b0}}, cin};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lo_q   <= '0;
          x_hi_q <= '0;
          y_hi_q <= '0;
        end else begin
          lo_q   <= lo_sum;
          x_hi_q <= x[WIDTH-1:LoW];
          y_hi_q <= y[WIDTH-1:LoW];
        end
      end

      assign hi_sum = {1'b0, x_hi_q} + {1'b0, y_hi_q} + {{HiW{1'b0}}, lo_q[LoW]};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_q <= '0;
        end else begin
          res_q <= {hi_sum, lo_q[LoW-1:0]};
        end
      end

      assign {cout, A} = res_q;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: four configurations share clock, reset and carry-in, and are checked
// every cycle against a reference built from plain integer addition and a latency shift array.
module tb_full_adder;

  logic       clk;
  logic       rst_n;
  logic       cin;

  logic       x1, y1, a1, c1;
  logic [7:0] x8, y8, a8;
  logic       c8;
  logic [3:0] x4, y4, a4;
  logic       c4;
  logic [4:0] x5, y5, a5;
  logic       c5;

  full_adder #(.WIDTH(1), .PIPE_STAGES(1)) u_w1p1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .cin(cin), .A(a1), .cout(c1)
  );
  full_adder #(.WIDTH(8), .PIPE_STAGES(2)) u_w8p2 (
    .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .cin(cin), .A(a8), .cout(c8)
  );
  full_adder #(.WIDTH(4), .PIPE_STAGES(0)) u_w4p0 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .cin(cin), .A(a4), .cout(c4)
  );
  full_adder #(.WIDTH(5), .PIPE_STAGES(2)) u_w5p2 (
    .clk(clk), .rst_n(rst_n), .x(x5), .y(y5), .cin(cin), .A(a5), .cout(c5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference: the full-precision sum, delayed by the configured latency; reset zeroes it all.
  logic [1:0] m1;
  logic [8:0] m8 [2];
  logic [5:0] m5 [2];

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge();
    int unsigned s1, s8, s5;
    s1 = 32'(x1) + 32'(y1) + 32'(cin);
    s8 = 32'(x8) + 32'(y8) + 32'(cin);
    s5 = 32'(x5) + 32'(y5) + 32'(cin);
    if (!rst_n) begin
      m1    = '0;
      m8[0] = '0; m8[1] = '0;
      m5[0] = '0; m5[1] = '0;
    end else begin
      m1    = s1[1:0];
      m8[1] = m8[0]; m8[0] = s8[8:0];
      m5[1] = m5[0]; m5[0] = s5[5:0];
    end
  endtask

  // One cycle: check the combinational instance, take an edge, check the registered ones.
  task automatic tick();
    int unsigned s4;
    #1;
    s4 = 32'(x4) + 32'(y4) + 32'(cin);
    check("w4p0_comb", 65'({c4, a4}), 65'(s4[4:0]));
    @(posedge clk);
    model_edge();
    #1;
    check("w1p1", 65'({c1, a1}), 65'(m1));
    check("w8p2", 65'({c8, a8}), 65'(m8[1]));
    check("w5p2", 65'({c5, a5}), 65'(m5[1]));
  endtask

  task automatic set_all(input logic [7:0] xv, input logic [7:0] yv, input logic cv);
    x1 = xv[0]; y1 = yv[0];
    x8 = xv;    y8 = yv;
    x4 = xv[3:0]; y4 = yv[3:0];
    x5 = xv[4:0]; y5 = yv[4:0];
    cin = cv;
  endtask

  initial begin
    rst_n = 1'b0;
    set_all(8'h00, 8'h00, 1'b0);

    // Reset with all-ones inputs held for two edges: outputs must stay zero.
    set_all(8'hFF, 8'hFF, 1'b1);
    tick();
    check("rst_w1p1_hold", 65'({c1, a1}), 65'd0);
    tick();
    check("rst_w8p2_hold", 65'({c8, a8}), 65'd0);
    rst_n = 1'b1;
    tick();
    check("rst_release_w1p1", 65'({c1, a1}), 65'b11);

    // Exhaustive 1-bit sweep, one combination per cycle.
    for (int i = 0; i < 8; i++) begin
      set_all({7'd0, i[2]}, {7'd0, i[1]}, i[0]);
      tick();
    end

    // Back-to-back alternation of 111 and 000.
    for (int i = 0; i < 6; i++) begin
      set_all((i % 2 == 0) ? 8'hFF : 8'h00, (i % 2 == 0) ? 8'hFF : 8'h00, i % 2 == 0);
      tick();
    end

    // Eight-bit carry ripple through the two-stage split.
    set_all(8'hFF, 8'h01, 1'b0);
    tick();
    set_all(8'h7F, 8'h80, 1'b1);
    tick();
    check("ripple_ff_01", 65'({c8, a8}), 65'h100);
    set_all(8'h12, 8'h34, 1'b0);
    tick();
    check("ripple_7f_80_1", 65'({c8, a8}), 65'h100);
    set_all(8'h00, 8'h00, 1'b0);
    tick();
    check("ripple_12_34", 65'({c8, a8}), 65'h046);

    // Drain, then a mid-pipeline reset pulse must flush the in-flight sum.
    tick();
    tick();
    set_all(8'hFF, 8'h01, 1'b0);
    tick();
    set_all(8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    check("flush_w8p2_a", 65'({c8, a8}), 65'd0);
    rst_n = 1'b1;
    tick();
    check("flush_w8p2_b", 65'({c8, a8}), 65'd0);
    tick();
    check("flush_w8p2_c", 65'({c8, a8}), 65'd0);

    // Combinational mode ignores reset.
    rst_n = 1'b0;
    set_all(8'h0F, 8'h0F, 1'b1);
    #1;
    check("comb_f_f_1", 65'({c4, a4}), 65'h1F);
    tick();
    rst_n = 1'b1;

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      set_all(8'($urandom), 8'($urandom), 1'($urandom));
      rst_n = ($urandom_range(0, 15) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
